drop_test_run_ctrl: RTL

//  Sequences one run of the egg-drop program on the pipelined CPU in board_top.

---
 rtl/drop_test_run_ctrl.sv | 123 ++++++++++++
 1 files changed

// File: rtl/drop_test_run_ctrl.sv
// rtl/drop_test_run_ctrl.sv - sequences one egg-drop run: load, CPU release, halt/timeout detect, result latch
module drop_test_run_ctrl #(
    parameter int DATA_W      = 16,
    parameter int HALT_CYCLES = 4,
    parameter int TIMEOUT     = 1000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              is_init_floors,
    input  logic              is_init_resistance,
    input  logic              start,
    input  logic [31:0]       cpu_pc,
    input  logic [31:0]       cpu_attempt_count,
    input  logic [31:0]       cpu_broken_count,
    input  logic              cpu_is_last_broken,
    output logic              cpu_rst_n,
    output logic [31:0]       init_floors,
    output logic [31:0]       init_resistance,
    output logic              busy,
    output logic              done,
    output logic              timeout,
    output logic              cfg_error,
    output logic [31:0]       run_cycles,
    output logic [31:0]       result_attempt_count,
    output logic [31:0]       result_broken_count,
    output logic              result_is_last_broken
);
    localparam int          SW        = $clog2(HALT_CYCLES);
    localparam logic [31:0] TIMEOUT_W = 32'(TIMEOUT);

    typedef enum logic [1:0] {S_IDLE, S_ARM, S_RUN, S_DONE} state_t;

    state_t state, state_next;

    logic          floors_q, resist_q, start_q;
    logic [31:0]   prev_pc;
    logic [SW-1:0] stall_cnt;

    logic          floors_edge, resist_edge, start_edge, idle_like;
    logic          load_floors, load_resist, start_req, start_ok, start_bad;
    logic [31:0]   rc_inc;
    logic [SW-1:0] stall_next;
    logic          halt_hit, to_hit, run_exit;

    always_comb begin
        floors_edge = is_init_floors & ~floors_q;
        resist_edge = is_init_resistance & ~resist_q;
        start_edge  = start & ~start_q;
        idle_like   = (state == S_IDLE) || (state == S_DONE);
        load_floors = idle_like & floors_edge;
        load_resist = idle_like & resist_edge;
        // a load in the same cycle wins over start so the run never sees a half-updated config
        start_req   = idle_like & start_edge & ~floors_edge & ~resist_edge;
        start_ok    = start_req & (init_floors != 32'd0);
        start_bad   = start_req & (init_floors == 32'd0);
        rc_inc      = (run_cycles == 32'hFFFF_FFFF) ? run_cycles : run_cycles + 32'd1;
        stall_next  = (cpu_pc == prev_pc) ? stall_cnt + SW'(1) : '0;
        halt_hit    = (stall_next == SW'(HALT_CYCLES - 1));
        to_hit      = (rc_inc >= TIMEOUT_W);
        run_exit    = (state == S_RUN) & (halt_hit | to_hit);
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE, S_DONE: if (start_ok) state_next = S_ARM;
            S_ARM:          state_next = S_RUN;
            S_RUN:          if (run_exit) state_next = S_DONE;
            default:        state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state                 <= S_IDLE;
            floors_q              <= 1'b0;
            resist_q              <= 1'b0;
            start_q               <= 1'b0;
            prev_pc               <= '0;
            stall_cnt             <= '0;
            init_floors           <= '0;
            init_resistance       <= '0;
            timeout               <= 1'b0;
            cfg_error             <= 1'b0;
            run_cycles            <= '0;
            result_attempt_count  <= '0;
            result_broken_count   <= '0;
            result_is_last_broken <= 1'b0;
        end else begin
            state    <= state_next;
            floors_q <= is_init_floors;
            resist_q <= is_init_resistance;
            start_q  <= start;
            prev_pc  <= cpu_pc;
            if (load_floors) init_floors     <= 32'(in_data);
            if (load_resist) init_resistance <= 32'(in_data);
            if (start_bad) cfg_error <= 1'b1;
            if (start_ok) begin
                cfg_error <= 1'b0;
                timeout   <= 1'b0;
            end
            if (state == S_ARM) begin
                run_cycles <= '0;
                stall_cnt  <= '0;
            end
            if (state == S_RUN) begin
                run_cycles <= rc_inc;
                stall_cnt  <= stall_next;
            end
            if (run_exit) begin
                timeout               <= ~halt_hit;
                result_attempt_count  <= cpu_attempt_count;
                result_broken_count   <= cpu_broken_count;
                result_is_last_broken <= cpu_is_last_broken;
            end
        end
    end

    assign cpu_rst_n = (state == S_RUN);
    assign busy      = (state == S_ARM) || (state == S_RUN);
    assign done      = (state == S_DONE);
endmodule
